// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed seven-segment driver for the parking-system front panel.
//   Glyph codes are double-buffered: a load goes into a pending buffer and is
//   only copied to the display buffer at a frame boundary, so a frame never
//   shows a mix of old and new digits. Adds per-digit blanking and blinking.
//
// Parameters
//   NUM_DIGITS   number of multiplexed digits (>=1)
//   PRESCALE     clock cycles each digit stays lit (>=2)
//   BLINK_FRAMES full scan frames per blink half-period (>=1)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   digits_in  packed glyph codes, digit i at [4i+3:4i], digit 0 rightmost
//   load       one-cycle strobe capturing digits_in into the pending buffer
//   blank_mask bit i forces digit i dark (live)
//   blink_mask bit i darkens digit i during the blink-off phase (live)
//   seg        active-low segments {a,b,c,d,e,f,g}
//   an         active-low digit enables, one-hot-low
//   frame_done one-cycle pulse, coincident with an[0] going low after a wrap
//
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN: when defined, zero digits above the highest
//   nonzero digit are dark (digit 0 is never suppressed).

module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PC_W  = $clog2(PRESCALE);
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  logic [PC_W-1:0]         pcnt;
  logic [IDX_W-1:0]        idx;
  logic [FC_W-1:0]         fcnt;
  logic                    blink_on;
  logic [4*NUM_DIGITS-1:0] pend;
  logic                    pend_v;
  logic [4*NUM_DIGITS-1:0] disp;
  logic                    wrap_q;

  logic                    tick;
  logic                    boundary;
  logic [3:0]              cur_code;
  logic                    cur_blank;
  logic                    cur_blink;
  logic                    cur_lz;
  logic                    dark;
  logic [NUM_DIGITS-1:0]   an_next;
  logic [NUM_DIGITS-1:0]   lz_dark;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    glyph = 7'b1111111;
    case (code)
      4'd0:  glyph = 7'b0000001;
      4'd1:  glyph = 7'b1001111;
      4'd2:  glyph = 7'b0010010;
      4'd3:  glyph = 7'b0000110;
      4'd4:  glyph = 7'b1001100;
      4'd5:  glyph = 7'b0100100;
      4'd6:  glyph = 7'b0100000;
      4'd7:  glyph = 7'b0001111;
      4'd8:  glyph = 7'b0000000;
      4'd9:  glyph = 7'b0000100;
      4'd10: glyph = 7'b1001000; // H
      4'd11: glyph = 7'b0001000; // A
      4'd12: glyph = 7'b0011000; // P
      4'd13: glyph = 7'b0111000; // F
      4'd14: glyph = 7'b1111110; // -
      4'd15: glyph = 7'b1111111; // blank
    endcase
  endfunction

  assign tick     = (pcnt == PC_LAST);
  assign boundary = tick && (idx == IDX_LAST);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic nz_above;

  // Walk down from the top digit; zeros are dark until the first nonzero
  // code is seen. Any code other than 0 counts as nonzero.
  always_comb begin
    nz_above = 1'b0;
    lz_dark  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (!nz_above && (disp[4*i +: 4] == 4'd0)) lz_dark[i] = 1'b1;
      if (disp[4*i +: 4] != 4'd0) nz_above = 1'b1;
    end
  end
`else
  assign lz_dark = '0;
`endif

  // Per-digit select by compare rather than direct indexing, so idx never
  // addresses past NUM_DIGITS-1 when NUM_DIGITS is not a power of two.
  always_comb begin
    cur_code  = 4'hf;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_lz    = 1'b0;
    an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code   = disp[4*i +: 4];
        cur_blank  = blank_mask[i];
        cur_blink  = blink_mask[i];
        cur_lz     = lz_dark[i];
        an_next[i] = 1'b0;
      end
    end
  end

  assign dark = cur_blank || (cur_blink && !blink_on) || cur_lz;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt       <= '0;
      idx        <= '0;
      fcnt       <= '0;
      blink_on   <= 1'b1;
      pend       <= '1;
      pend_v     <= 1'b0;
      disp       <= '1;
      wrap_q     <= 1'b0;
      seg        <= 7'b1111111;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // The output register lags idx by one cycle, so the wrap flag is
      // delayed once more to land on the same cycle as an[0] going low.
      wrap_q     <= boundary;
      frame_done <= wrap_q;

      if (boundary) begin
        if (pend_v) begin
          disp   <= pend;
          pend_v <= 1'b0;
        end
        if (fcnt == FC_LAST) begin
          fcnt     <= '0;
          blink_on <= ~blink_on;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end

      // Placed after the boundary transfer: a coincident load keeps the new
      // data pending for the next frame while disp takes the old pend.
      if (load) begin
        pend   <= digits_in;
        pend_v <= 1'b1;
      end

      an  <= an_next;
      seg <= dark ? 7'b1111111 : glyph(cur_code);
    end
  end

endmodule
